multi_pipe_rule_stage: RTL and testbench



---
 rtl/multi_pipe_rule_stage.sv | 201 ++++++++++++++++++++
 tb/tb_multi_pipe_rule_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pipe_rule_stage.sv
// multi_pipe_rule_stage
// Carries the dual-port rule IDs and action-valid flags of NUM_PIPES parallel
// classification pipelines through DEPTH stall/flush-capable register stages.
// It then registers a per-port priority merge that selects the lowest matching
// rule ID (ties go to the lowest pipe index). It also keeps a saturating count
// of resolved hits.
module multi_pipe_rule_stage #(
   parameter int RULE_ID   = 14,
   parameter int NUM_PIPES = 3,
   parameter int DEPTH     = 1,
   parameter int CNT_W     = 32
) (
   input  logic                                                  clk,
   input  logic                                                  RSTn,
   input  logic                                                  stall,
   input  logic                                                  flush,
   input  logic                                                  clear_cnt,
   input  logic [1:0]                                            pkt_valid_in,
   input  logic [NUM_PIPES*2*RULE_ID-1:0]                        rule_in,
   input  logic [NUM_PIPES*2-1:0]                                act_valid_in,
   output logic [1:0]                                            pkt_valid_out,
   output logic [NUM_PIPES*2*RULE_ID-1:0]                        rule_out,
   output logic [NUM_PIPES*2-1:0]                                act_valid_out,
   output logic [1:0]                                            best_valid,
   output logic [1:0]                                            best_hit,
   output logic [2*RULE_ID-1:0]                                  best_rule,
   output logic [2*((NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1)-1:0] best_pipe,
   output logic [CNT_W-1:0]                                      hit_cnt
);

   localparam int PIPE_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
   localparam int NK     = 2 * NUM_PIPES;
   localparam int RW     = NK * RULE_ID;

   // Delay stages
   logic [1:0]        pkt_q  [DEPTH];
   logic [1:0]        pkt_d  [DEPTH];
   logic [RW-1:0]     rule_q [DEPTH];
   logic [RW-1:0]     rule_d [DEPTH];
   logic [NK-1:0]     act_q  [DEPTH];
   logic [NK-1:0]     act_d  [DEPTH];

   // Action valids masked by their own port's packet valid (bit 2j+p -> port p)
   logic [NK-1:0]     act_gated_s;

   // Combinational merge result
   logic [1:0]            m_hit_s;
   logic [2*RULE_ID-1:0]  m_rule_s;
   logic [2*PIPE_W-1:0]   m_pipe_s;
   logic [RULE_ID-1:0]    cand_s;
   logic                  take_s;

   // Merge register
   logic [1:0]            best_valid_q, best_valid_d;
   logic [1:0]            best_hit_q,   best_hit_d;
   logic [2*RULE_ID-1:0]  best_rule_q,  best_rule_d;
   logic [2*PIPE_W-1:0]   best_pipe_q,  best_pipe_d;

   // Hit counter
   logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
   logic [CNT_W:0]        inc_s;
   logic [CNT_W:0]        sum_s;
   logic [CNT_W-1:0]      sat_s;

   assign act_gated_s = act_valid_in & {NUM_PIPES{pkt_valid_in}};

   // Stage next-state: flush clears everything, stall holds, otherwise shift
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pkt_d[i]  = pkt_q[i];
         rule_d[i] = rule_q[i];
         act_d[i]  = act_q[i];
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            pkt_d[i]  = 2'b00;
            rule_d[i] = '0;
            act_d[i]  = '0;
         end
      end else if (!stall) begin
         pkt_d[0]  = pkt_valid_in;
         rule_d[0] = rule_in;
         act_d[0]  = act_gated_s;
         for (int i = 1; i < DEPTH; i++) begin
            pkt_d[i]  = pkt_q[i-1];
            rule_d[i] = rule_q[i-1];
            act_d[i]  = act_q[i-1];
         end
      end else begin
         // stall: defaults already hold every stage
         pkt_d[0] = pkt_q[0];
      end
   end

   // Stage registers
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) begin
            pkt_q[i]  <= 2'b00;
            rule_q[i] <= '0;
            act_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pkt_q[i]  <= pkt_d[i];
            rule_q[i] <= rule_d[i];
            act_q[i]  <= act_d[i];
         end
      end
   end

   // Per-port compare tree: strict less-than keeps the lowest pipe on ties
   always_comb begin
      m_hit_s  = 2'b00;
      m_rule_s = '0;
      m_pipe_s = '0;
      cand_s   = '0;
      take_s   = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < NUM_PIPES; j++) begin
            cand_s = rule_q[DEPTH-1][(2*j+p)*RULE_ID +: RULE_ID];
            take_s = act_q[DEPTH-1][2*j+p] &&
                     (!m_hit_s[p] || (cand_s < m_rule_s[p*RULE_ID +: RULE_ID]));
            m_rule_s[p*RULE_ID +: RULE_ID] = take_s ? cand_s : m_rule_s[p*RULE_ID +: RULE_ID];
            m_pipe_s[p*PIPE_W +: PIPE_W]   = take_s ? PIPE_W'(j) : m_pipe_s[p*PIPE_W +: PIPE_W];
            m_hit_s[p]                     = m_hit_s[p] | take_s;
         end
         m_hit_s[p] = m_hit_s[p] & pkt_q[DEPTH-1][p];
      end
   end

   // Merge register next-state
   always_comb begin
      best_valid_d = best_valid_q;
      best_hit_d   = best_hit_q;
      best_rule_d  = best_rule_q;
      best_pipe_d  = best_pipe_q;
      if (flush) begin
         best_valid_d = 2'b00;
         best_hit_d   = 2'b00;
         best_rule_d  = '0;
         best_pipe_d  = '0;
      end else if (!stall) begin
         best_valid_d = pkt_q[DEPTH-1];
         best_hit_d   = m_hit_s;
         best_rule_d  = m_rule_s;
         best_pipe_d  = m_pipe_s;
      end else begin
         best_valid_d = best_valid_q;
      end
   end

   // Merge register
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         best_valid_q <= 2'b00;
         best_hit_q   <= 2'b00;
         best_rule_q  <= '0;
         best_pipe_q  <= '0;
      end else begin
         best_valid_q <= best_valid_d;
         best_hit_q   <= best_hit_d;
         best_rule_q  <= best_rule_d;
         best_pipe_q  <= best_pipe_d;
      end
   end

   // Counter next-state: the presented merge result is counted on the edge that
   // replaces it, so a result held by stall is counted exactly once
   always_comb begin
      inc_s = (CNT_W+1)'(best_hit_q[0]) + (CNT_W+1)'(best_hit_q[1]);
      sum_s = {1'b0, hit_cnt_q} + inc_s;
      sat_s = sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
      if (clear_cnt) begin
         hit_cnt_d = '0;
      end else if (flush || !stall) begin
         hit_cnt_d = sat_s;
      end else begin
         hit_cnt_d = hit_cnt_q;
      end
   end

   // Hit counter register
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         hit_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign pkt_valid_out = pkt_q[DEPTH-1];
   assign rule_out      = rule_q[DEPTH-1];
   assign act_valid_out = act_q[DEPTH-1];
   assign best_valid    = best_valid_q;
   assign best_hit      = best_hit_q;
   assign best_rule     = best_rule_q;
   assign best_pipe     = best_pipe_q;
   assign hit_cnt       = hit_cnt_q;

endmodule

// File: tb/tb_multi_pipe_rule_stage.sv
// Directed bench for multi_pipe_rule_stage (NUM_PIPES=3, DEPTH=2, CNT_W=4).
module tb_multi_pipe_rule_stage;

   localparam int RULE_ID   = 14;
   localparam int NUM_PIPES = 3;
   localparam int DEPTH     = 2;
   localparam int CNT_W     = 4;
   localparam int PIPE_W    = 2;

   logic                          clk = 1'b0;
   logic                          RSTn;
   logic                          stall, flush, clear_cnt;
   logic [1:0]                    pkt_valid_in;
   logic [NUM_PIPES*2*RULE_ID-1:0] rule_in;
   logic [NUM_PIPES*2-1:0]        act_valid_in;
   logic [1:0]                    pkt_valid_out;
   logic [NUM_PIPES*2*RULE_ID-1:0] rule_out;
   logic [NUM_PIPES*2-1:0]        act_valid_out;
   logic [1:0]                    best_valid, best_hit;
   logic [2*RULE_ID-1:0]          best_rule;
   logic [2*PIPE_W-1:0]           best_pipe;
   logic [CNT_W-1:0]              hit_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   multi_pipe_rule_stage #(
      .RULE_ID(RULE_ID), .NUM_PIPES(NUM_PIPES), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .RSTn(RSTn), .stall(stall), .flush(flush), .clear_cnt(clear_cnt),
      .pkt_valid_in(pkt_valid_in), .rule_in(rule_in), .act_valid_in(act_valid_in),
      .pkt_valid_out(pkt_valid_out), .rule_out(rule_out), .act_valid_out(act_valid_out),
      .best_valid(best_valid), .best_hit(best_hit), .best_rule(best_rule),
      .best_pipe(best_pipe), .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // a = pipe0, b = pipe1, c = pipe2; suffix is the port
   task automatic drive(input logic [1:0] pv, input logic [5:0] av,
                        input logic [13:0] a0, input logic [13:0] a1,
                        input logic [13:0] b0, input logic [13:0] b1,
                        input logic [13:0] c0, input logic [13:0] c1);
      pkt_valid_in = pv;
      act_valid_in = av;
      rule_in      = {c1, c0, b1, b0, a1, a0};
   endtask

   task automatic idle();
      drive(2'b00, 6'b000000, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0);
   endtask

   // single entry on port 0 from pipe 0
   task automatic drive_id(input logic [13:0] id);
      drive(2'b01, 6'b000001, id, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0);
   endtask

   task automatic drive_dual();
      drive(2'b11, 6'b111111, 14'd5, 14'd5, 14'd3, 14'd3, 14'd9, 14'd9);
   endtask

   initial begin
      RSTn = 1'b0; stall = 1'b0; flush = 1'b0; clear_cnt = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pkt_valid_out", pkt_valid_out, 2'b00);
      check("rst_rule_out",      rule_out, '0);
      check("rst_best_valid",    best_valid, 2'b00);
      check("rst_hit_cnt",       hit_cnt, 4'd0);
      RSTn = 1'b1;

      // latency and basic merge
      drive_dual();
      tick();
      idle();
      check("lat_s0_not_out", pkt_valid_out, 2'b00);
      tick();
      check("lat_rule_out", rule_out, {14'd9, 14'd9, 14'd3, 14'd3, 14'd5, 14'd5});
      check("lat_act_out",  act_valid_out, 6'b111111);
      check("lat_pkt_out",  pkt_valid_out, 2'b11);
      check("lat_best_early", best_valid, 2'b00);
      tick();
      check("lat_best_rule",  best_rule, {14'd3, 14'd3});
      check("lat_best_pipe",  best_pipe, {2'd1, 2'd1});
      check("lat_best_hit",   best_hit, 2'b11);
      check("lat_best_valid", best_valid, 2'b11);
      tick();
      check("lat_hit_cnt", hit_cnt, 4'd2);

      // gating: port 1 packet absent
      drive(2'b01, 6'b111111, 14'd4, 14'd8, 14'd6, 14'd8, 14'd2, 14'd8);
      tick();
      idle();
      tick();
      check("gate_act_out",  act_valid_out, 6'b010101);
      check("gate_rule_out", rule_out, {14'd8, 14'd2, 14'd8, 14'd6, 14'd8, 14'd4});
      tick();
      check("gate_best_valid", best_valid, 2'b01);
      check("gate_best_hit",   best_hit, 2'b01);
      check("gate_best_rule",  best_rule, {14'd0, 14'd2});
      check("gate_best_pipe",  best_pipe, {2'd0, 2'd2});
      tick();
      check("gate_hit_cnt", hit_cnt, 4'd3);

      // tie-break: pipes 0 and 2 both report 7, pipe 1 has no action
      drive(2'b01, 6'b010001, 14'd7, 14'd0, 14'd1, 14'd0, 14'd7, 14'd0);
      tick();
      idle();
      tick();
      tick();
      check("tie_best_rule", best_rule, {14'd0, 14'd7});
      check("tie_best_pipe", best_pipe, {2'd0, 2'd0});
      check("tie_best_hit",  best_hit, 2'b01);
      tick();
      check("tie_hit_cnt", hit_cnt, 4'd4);

      // stall for 3 cycles while ID 2 waits to enter stage 0
      drive_id(14'd1);
      tick();
      drive_id(14'd2);
      stall = 1'b1;
      repeat (3) tick();
      check("stall_s1_held",  pkt_valid_out, 2'b00);
      check("stall_best_held", best_valid, 2'b00);
      check("stall_cnt_held", hit_cnt, 4'd4);
      stall = 1'b0;
      tick();
      drive_id(14'd3);
      tick();
      check("stall_seq1", best_rule, {14'd0, 14'd1});
      check("stall_v1",   best_valid, 2'b01);
      drive_id(14'd4);
      tick();
      check("stall_seq2", best_rule, {14'd0, 14'd2});
      check("stall_cnt5", hit_cnt, 4'd5);
      idle();
      tick();
      check("stall_seq3", best_rule, {14'd0, 14'd3});
      tick();
      check("stall_seq4", best_rule, {14'd0, 14'd4});
      check("stall_cnt7", hit_cnt, 4'd7);
      tick();
      check("stall_seq_end", best_valid, 2'b00);
      check("stall_cnt8",    hit_cnt, 4'd8);

      // stall while merge register presents a hit: counted exactly once
      drive_id(14'd10);
      tick();
      idle();
      tick();
      tick();
      check("hold_best_rule", best_rule, {14'd0, 14'd10});
      stall = 1'b1;
      repeat (2) tick();
      check("hold_best_kept", best_rule, {14'd0, 14'd10});
      check("hold_cnt_kept",  hit_cnt, 4'd8);
      stall = 1'b0;
      tick();
      check("hold_cnt_once", hit_cnt, 4'd9);
      tick();
      check("hold_cnt_no_dup", hit_cnt, 4'd9);

      // flush with simultaneous stall and new input
      drive_id(14'd11);
      tick();
      drive_id(14'd12);
      tick();
      check("flush_pre_full", pkt_valid_out, 2'b01);
      drive_id(14'd13);
      flush = 1'b1;
      stall = 1'b1;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      check("flush_pkt_out",   pkt_valid_out, 2'b00);
      check("flush_act_out",   act_valid_out, 6'b000000);
      check("flush_rule_out",  rule_out, '0);
      check("flush_best_valid", best_valid, 2'b00);
      check("flush_best_hit",  best_hit, 2'b00);
      check("flush_cnt",       hit_cnt, 4'd9);
      drive_id(14'd14);
      tick();
      idle();
      check("flush_s1_empty", pkt_valid_out, 2'b00);
      check("flush_no_ghost", best_valid, 2'b00);
      tick();
      check("flush_next_rule", rule_out, {14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd14});
      check("flush_next_pkt",  pkt_valid_out, 2'b01);
      tick();
      check("flush_next_best", best_rule, {14'd0, 14'd14});
      tick();
      check("flush_next_cnt", hit_cnt, 4'd10);

      // saturation
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      check("cnt_cleared", hit_cnt, 4'd0);
      for (int k = 0; k < 9; k++) begin
         drive_dual();
         tick();
      end
      idle();
      tick();
      check("cnt_14", hit_cnt, 4'd14);
      tick();
      check("cnt_sat_plus2", hit_cnt, 4'd15);
      tick();
      check("cnt_sat_hold", hit_cnt, 4'd15);

      // clear beats a pending increment
      drive_dual();
      tick();
      idle();
      tick();
      tick();
      check("clr_hit_pending", best_hit, 2'b11);
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      check("clr_over_inc", hit_cnt, 4'd0);
      tick();
      check("clr_after", hit_cnt, 4'd0);

      // asynchronous reset mid-stream
      drive_dual();
      tick();
      drive(2'b11, 6'b111111, 14'd1, 14'd1, 14'd2, 14'd2, 14'd3, 14'd3);
      tick();
      drive_dual();
      tick();
      idle();
      tick();
      check("mid_pre_cnt",   hit_cnt, 4'd2);
      check("mid_pre_pkt",   pkt_valid_out, 2'b11);
      check("mid_pre_best",  best_rule, {14'd1, 14'd1});
      #2;
      RSTn = 1'b0;
      #1;
      check("arst_pkt_out",   pkt_valid_out, 2'b00);
      check("arst_act_out",   act_valid_out, 6'b000000);
      check("arst_rule_out",  rule_out, '0);
      check("arst_best_valid", best_valid, 2'b00);
      check("arst_best_hit",  best_hit, 2'b00);
      check("arst_best_rule", best_rule, '0);
      check("arst_best_pipe", best_pipe, '0);
      check("arst_hit_cnt",   hit_cnt, 4'd0);
      #2;
      RSTn = 1'b1;
      drive_dual();
      tick();
      idle();
      tick();
      check("post_rst_pkt", pkt_valid_out, 2'b11);
      tick();
      check("post_rst_best", best_rule, {14'd3, 14'd3});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
